blake_round_ctrl: RTL and testbench
===================================

BLAKE_ROUND_CTRL -- requirements
Module: blake_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, 16, compression rounds per block (BLAKE-512).
REQ-002 Parameter G_PER_ROUND, 8, G-function steps per round (4 column + 4 diagonal).
REQ-003 clk  input  1  single clock, all flops on rising edge.
REQ-004 rstb  input  1  reset, asynchronous, active-low.
REQ-005 blk_valid  input  1  message block, chain value and counter are presented to the datapath.
REQ-006 blk_ready  output  1  controller can accept a block.
REQ-007 hold  input  1  datapath stall: freezes step progress while in ROUND.
REQ-008 init_en  output  1  datapath loads v[0..15] from h, salt, counter and constants.
REQ-009 g_en  output  1  datapath executes one G step this cycle.
REQ-010 step_idx  output  7  global step index, 0..127.
REQ-011 round_idx  output  4  current round, step_idx[6:3].
REQ-012 g_sel  output  3  G instance within round, step_idx[2:0].
REQ-013 diag  output  1  diagonal half of round, step_idx[2].
REQ-014 sigma_row  output  4  sigma permutation row, round_idx mod 10.
REQ-015 fin_en  output  1  datapath applies finalization h' = h ^ s ^ v_lo ^ v_hi.
REQ-016 hash_valid  output  1  h' is stable and valid.
REQ-017 hash_ready  input  1  consumer accepts h'.

Function
REQ-018 The FSM SHALL have states IDLE, INIT, ROUND, FINAL and DONE.
REQ-019 blk_ready SHALL be 1 only in IDLE; acceptance is blk_valid & blk_ready on a rising edge, IDLE -> INIT.
REQ-020 INIT SHALL last exactly one cycle with init_en=1, step_idx=0, then ROUND.
REQ-021 In ROUND, g_en SHALL equal !hold; step_idx increments by 1 on each cycle with g_en=1.
REQ-022 ROUND -> FINAL SHALL occur on the edge where step_idx==127 and g_en=1; step_idx then wraps to 0.
REQ-023 FINAL SHALL last one cycle with fin_en=1, then DONE.
REQ-024 DONE SHALL hold hash_valid=1 until hash_valid & hash_ready, then IDLE; blk_ready rises the cycle after.
REQ-025 Latency with hold=0 SHALL be 131 cycles: acceptance edge T, INIT T+1, ROUND T+2..T+129, FINAL T+130, hash_valid from T+131.
REQ-026 sigma_row SHALL be round_idx for rounds 0..9 and round_idx-10 for rounds 10..15.
REQ-027 init_en, g_en, fin_en and hash_valid SHALL be mutually exclusive and 0 outside their states.
REQ-028 hold SHALL be ignored outside ROUND; hold at step 127 delays FINAL until released.
REQ-029 blk_valid in any state other than IDLE SHALL have no effect.
REQ-030 step_idx, round_idx, g_sel, diag and sigma_row SHALL be valid in ROUND and 0 in IDLE, INIT, FINAL and DONE.
REQ-031 All control outputs SHALL be registered or decoded only from state and step_idx, with no combinational path from inputs except g_en from hold.

Reset
REQ-032 rstb low SHALL force IDLE, step_idx=0, blk_ready=1 and all other outputs 0 asynchronously, including mid-ROUND.
REQ-033 After rstb deasserts, the first acceptance SHALL be possible on the first rising edge.

Structure
REQ-034 Package blake_pkg SHALL hold the state enum, NUM_ROUNDS, G_PER_ROUND, SIGMA_ROWS=10 and the step width.
REQ-035 Sub-module blake_step_counter SHALL implement the 7-bit step counter with enable, clear and wrap flag (step==127), instantiated once.
REQ-036 The sigma_row mod-10 mapping SHALL be a compare/subtract on round_idx, not a divider.

Verification
REQ-037 Single block, hold=0, hash_ready=1: hash_valid=1 exactly 131 cycles after acceptance, g_en high for 128 cycles.
REQ-038 hold=1 for 5 cycles at step 40 and at step 127: hash_valid at acceptance+141, step_idx frozen during hold.
REQ-039 Rounds 9, 10 and 15: sigma_row reads 9, 0 and 5; diag=1 for g_sel 4..7.
REQ-040 hash_ready=0 for 20 cycles in DONE: hash_valid stays 1, blk_ready stays 0, then IDLE after the handshake.
REQ-041 rstb pulsed low at step 77: all outputs reset immediately; a new block is accepted on the first edge after release.
REQ-042 blk_valid held high across back-to-back blocks: second acceptance one cycle after the hash handshake, with no INIT overlap.

Source files
------------

// File: rtl/blake_pkg.sv
// blake_pkg
//   Shared definitions for the BLAKE-512 round controller: controller state
//   encoding, round/step geometry and the sigma-row reduction helper.
package blake_pkg;

  localparam int NUM_ROUNDS  = 16;  // compression rounds per block
  localparam int G_PER_ROUND = 8;   // 4 column + 4 diagonal G steps
  localparam int SIGMA_ROWS  = 10;  // sigma table repeats every 10 rounds
  localparam int STEP_W      = 7;   // width of the global step index

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  // Rounds never exceed 15, so a single compare/subtract is a complete mod 10.
  function automatic logic [3:0] sigma_row_of(input logic [3:0] rnd);
    return (rnd >= 4'(SIGMA_ROWS)) ? rnd - 4'(SIGMA_ROWS) : rnd;
  endfunction

endpackage

// File: rtl/blake_step_counter.sv
// blake_step_counter
//   Global G-step counter for one compression.
//   clk    : clock, rising edge
//   rstb   : asynchronous active-low reset, counter -> 0
//   en     : advance by one step this cycle
//   clr    : synchronous clear (wins over en)
//   step_o : current step index
//   wrap_o : high while the counter sits on the last step
module blake_step_counter
  import blake_pkg::*;
#(
  parameter int W    = STEP_W,
  parameter int LAST = (1 << STEP_W) - 1
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] step_o,
  output logic         wrap_o
);

  logic [W-1:0] step_q;
  logic [W-1:0] step_d;

  assign wrap_o = (step_q == W'(LAST));
  assign step_o = step_q;

  always_comb begin
    step_d = step_q;
    if (clr) begin
      step_d = '0;
    end else if (en) begin
      // Explicit wrap so a non-power-of-two LAST still returns to 0.
      step_d = wrap_o ? '0 : step_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/blake_round_ctrl.sv
// blake_round_ctrl
//   Sequencer for one BLAKE-512 compression: accepts a block, pulses the
//   datapath through init, 128 G steps (optionally stalled by hold) and
//   finalization, then presents the hash until the consumer takes it.
//   Inputs : clk, rstb (async active-low), blk_valid, hold, hash_ready
//   Outputs: blk_ready, init_en, g_en, fin_en, hash_valid,
//            step_idx[6:0], round_idx[3:0], g_sel[2:0], diag, sigma_row[3:0]
//   All outputs decode from state/step only; g_en is the one exception and
//   follows !hold combinationally while in ROUND.
module blake_round_ctrl
  import blake_pkg::*;
#(
  parameter int NUM_ROUNDS  = blake_pkg::NUM_ROUNDS,
  parameter int G_PER_ROUND = blake_pkg::G_PER_ROUND
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic              hold,
  output logic              init_en,
  output logic              g_en,
  output logic [STEP_W-1:0] step_idx,
  output logic [3:0]        round_idx,
  output logic [2:0]        g_sel,
  output logic              diag,
  output logic [3:0]        sigma_row,
  output logic              fin_en,
  output logic              hash_valid,
  input  logic              hash_ready
);

  localparam int LAST_STEP = NUM_ROUNDS * G_PER_ROUND - 1;

  state_e            state_q;
  state_e            state_d;
  logic [STEP_W-1:0] step;
  logic              step_wrap;
  logic              in_round;
  logic              step_en;

  assign in_round = (state_q == ST_ROUND);
  assign step_en  = in_round && !hold;

  // Counter is held clear outside ROUND, so step_idx and everything derived
  // from it read 0 in every other state without extra gating.
  blake_step_counter #(
    .W    (STEP_W),
    .LAST (LAST_STEP)
  ) u_step_counter (
    .clk    (clk),
    .rstb   (rstb),
    .en     (step_en),
    .clr    (!in_round),
    .step_o (step),
    .wrap_o (step_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (blk_valid)              state_d = ST_INIT;
      ST_INIT:                              state_d = ST_ROUND;
      ST_ROUND: if (step_en && step_wrap)   state_d = ST_FINAL;
      ST_FINAL:                             state_d = ST_DONE;
      ST_DONE:  if (hash_ready)             state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign blk_ready  = (state_q == ST_IDLE);
  assign init_en    = (state_q == ST_INIT);
  assign g_en       = step_en;
  assign fin_en     = (state_q == ST_FINAL);
  assign hash_valid = (state_q == ST_DONE);

  assign step_idx  = step;
  assign round_idx = step[6:3];
  assign g_sel     = step[2:0];
  assign diag      = step[2];
  assign sigma_row = sigma_row_of(step[6:3]);

endmodule

// File: tb/tb_blake_round_ctrl.sv
module tb_blake_round_ctrl;

  logic       clk = 1'b0;
  logic       rstb;
  logic       blk_valid;
  logic       blk_ready;
  logic       hold;
  logic       init_en;
  logic       g_en;
  logic [6:0] step_idx;
  logic [3:0] round_idx;
  logic [2:0] g_sel;
  logic       diag;
  logic [3:0] sigma_row;
  logic       fin_en;
  logic       hash_valid;
  logic       hash_ready;

  int total = 0;
  int bad   = 0;

  blake_round_ctrl dut (
    .clk        (clk),
    .rstb       (rstb),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .hold       (hold),
    .init_en    (init_en),
    .g_en       (g_en),
    .step_idx   (step_idx),
    .round_idx  (round_idx),
    .g_sel      (g_sel),
    .diag       (diag),
    .sigma_row  (sigma_row),
    .fin_en     (fin_en),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {blk_ready, init_en, g_en, fin_en, hash_valid, step, round, g_sel, diag, sigma}
  function automatic logic [31:0] out_vec();
    return {8'd0, blk_ready, init_en, g_en, fin_en, hash_valid,
            step_idx, round_idx, g_sel, diag, sigma_row};
  endfunction

  function automatic logic [31:0] pack_exp(input bit rdy, input bit ini, input bit g,
                                           input bit fin, input bit hv, input int step);
    int r;
    int gs;
    r  = step / 8;
    gs = step % 8;
    return {8'd0, rdy, ini, g, fin, hv, 7'(step), 4'(r), 3'(gs),
            (gs >= 4) ? 1'b1 : 1'b0, 4'(r % 10)};
  endfunction

  localparam logic [31:0] IDLE_VEC = {8'd0, 5'b10000, 7'd0, 4'd0, 3'd0, 1'b0, 4'd0};

  task automatic do_reset();
    rstb = 1'b0;
    blk_valid = 1'b0;
    hold = 1'b0;
    hash_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
  endtask

  // Observations from the clean block, indexed by step.
  int obs_round [128];
  int obs_gsel  [128];
  int obs_diag  [128];
  int obs_sigma [128];

  typedef struct {
    int step;
    int rnd;
    int gs;
    int dg;
    int sg;
  } vec_t;

  vec_t tbl [9];

  // Reference model: progress count through one compression.
  // -1 = waiting for a block, 0 = init, 1..128 = G step (prog-1), 129 = final, 130 = done.
  int prog;

  initial begin
    int k;
    int lat;
    int gcnt;
    bit done40;
    bit done127;
    int n;

    tbl[0] = '{3,   0,  3, 0, 0};
    tbl[1] = '{44,  5,  4, 1, 5};
    tbl[2] = '{72,  9,  0, 0, 9};
    tbl[3] = '{76,  9,  4, 1, 9};
    tbl[4] = '{80,  10, 0, 0, 0};
    tbl[5] = '{87,  10, 7, 1, 0};
    tbl[6] = '{120, 15, 0, 0, 5};
    tbl[7] = '{124, 15, 4, 1, 5};
    tbl[8] = '{127, 15, 7, 1, 5};

    // ---------------- reset state (blk_valid high is ignored while in reset)
    rstb = 1'b0;
    blk_valid = 1'b1;
    hold = 1'b1;
    hash_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", out_vec(), IDLE_VEC);
    do_reset();
    @(negedge clk);
    chk("idle_after_reset", out_vec(), IDLE_VEC);

    // ---------------- single block, no stalls
    hash_ready = 1'b1;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    k = 1;
    chk("init_cycle", out_vec(), pack_exp(0, 1, 0, 0, 0, 0));
    lat = 0;
    gcnt = 0;
    while (k <= 300) begin
      if (hash_valid) begin
        lat = k;
        break;
      end
      if (g_en) begin
        gcnt++;
        obs_round[step_idx] = int'(round_idx);
        obs_gsel[step_idx]  = int'(g_sel);
        obs_diag[step_idx]  = int'(diag);
        obs_sigma[step_idx] = int'(sigma_row);
      end
      if (k == 130) chk("final_cycle", out_vec(), pack_exp(0, 0, 0, 1, 0, 0));
      @(negedge clk);
      k++;
    end
    chk("latency_nohold", lat, 131);
    chk("g_en_count", gcnt, 128);
    @(negedge clk);
    chk("idle_after_hash", out_vec(), IDLE_VEC);

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("round_at_%0d", tbl[i].step), obs_round[tbl[i].step], tbl[i].rnd);
      chk($sformatf("gsel_at_%0d",  tbl[i].step), obs_gsel[tbl[i].step],  tbl[i].gs);
      chk($sformatf("diag_at_%0d",  tbl[i].step), obs_diag[tbl[i].step],  tbl[i].dg);
      chk($sformatf("sigma_at_%0d", tbl[i].step), obs_sigma[tbl[i].step], tbl[i].sg);
    end

    // ---------------- hold for 5 cycles at step 40 and at step 127
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    k = 1;
    lat = 0;
    done40 = 1'b0;
    done127 = 1'b0;
    while (k <= 300) begin
      if (hash_valid) begin
        lat = k;
        break;
      end
      if (k >= 2 && k <= 140 && !fin_en && !init_en &&
          ((step_idx == 7'd40 && !done40) || (step_idx == 7'd127 && !done127))) begin
        logic [6:0] s;
        s = step_idx;
        for (int j = 0; j < 5; j++) begin
          hold = 1'b1;
          #1;
          chk($sformatf("hold_gen_s%0d", s), g_en, 0);
          chk($sformatf("hold_step_s%0d", s), step_idx, s);
          @(negedge clk);
          k++;
        end
        hold = 1'b0;
        if (s == 7'd40) done40 = 1'b1;
        else done127 = 1'b1;
        continue;
      end
      @(negedge clk);
      k++;
    end
    chk("latency_hold", lat, 141);
    @(negedge clk);

    // ---------------- consumer stalls 20 cycles in DONE
    hash_ready = 1'b0;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    n = 0;
    while (!hash_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_done", hash_valid, 1);
    for (int j = 0; j < 20; j++) begin
      chk("done_stall", out_vec(), pack_exp(0, 0, 0, 0, 1, 0));
      @(negedge clk);
    end
    hash_ready = 1'b1;
    chk("done_handshake_cycle", hash_valid, 1);
    @(negedge clk);
    chk("idle_after_stall", out_vec(), IDLE_VEC);

    // ---------------- asynchronous reset at step 77
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    n = 0;
    while (!(step_idx == 7'd77 && g_en) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_step77", step_idx, 77);
    #2 rstb = 1'b0;
    #1;
    chk("async_reset_mid_round", out_vec(), IDLE_VEC);
    @(negedge clk);
    chk("reset_held", out_vec(), IDLE_VEC);
    rstb = 1'b1;
    blk_valid = 1'b1;
    @(negedge clk);
    chk("accept_first_edge", out_vec(), pack_exp(0, 1, 0, 0, 0, 0));
    blk_valid = 1'b0;
    do_reset();
    @(negedge clk);

    // ---------------- back-to-back blocks with blk_valid held high
    hash_ready = 1'b1;
    blk_valid = 1'b1;
    n = 0;
    while (!hash_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done", out_vec(), pack_exp(0, 0, 0, 0, 1, 0));
    @(negedge clk);
    chk("b2b_idle_gap", out_vec(), IDLE_VEC);
    @(negedge clk);
    chk("b2b_second_init", out_vec(), pack_exp(0, 1, 0, 0, 0, 0));
    blk_valid = 1'b0;
    do_reset();

    // ---------------- randomized run against the progress model
    prog = -1;
    for (int c = 0; c < 4000; c++) begin
      bit rdy;
      bit ini;
      bit g;
      bit fin;
      bit hv;
      int stp;
      @(negedge clk);
      blk_valid  = ($urandom_range(0, 1) == 1);
      hold       = ($urandom_range(0, 3) == 0);
      hash_ready = ($urandom_range(0, 2) != 0);
      #1;
      rdy = (prog < 0);
      ini = (prog == 0);
      g   = (prog >= 1 && prog <= 128) && !hold;
      fin = (prog == 129);
      hv  = (prog == 130);
      stp = (prog >= 1 && prog <= 128) ? prog - 1 : 0;
      chk($sformatf("rand_cycle_%0d", c), out_vec(), pack_exp(rdy, ini, g, fin, hv, stp));
      @(posedge clk);
      if (prog < 0) begin
        if (blk_valid) prog = 0;
      end else if (prog == 130) begin
        if (hash_ready) prog = -1;
      end else if (prog >= 1 && prog <= 128) begin
        if (!hold) prog++;
      end else begin
        prog++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
